// File: rtl/keypad_scan_debounce_param.sv
// Purpose : scan a ROWS x COLS active-low keypad, debounce on whole-scan boundaries, keep a key history and emit press/repeat/release pulses.
// Latency : a stable press is accepted after DEBOUNCE_SCANS full scans (plus 2-flop sync and up to one partial scan); pulses appear the cycle after scan-end.
// Backpress: none; event pulses are single-cycle strobes with no handshake, consumers must sample them every cycle.
module keypad_scan_debounce_param #(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SCAN_CYCLES    = 8,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int HISTORY        = 2,
    parameter int REPEAT_SCANS   = 0
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic [COLS-1:0]                                        keypad_column,
    output logic [ROWS-1:0]                                        keypad_row,
    output logic [HISTORY*($clog2(ROWS)+$clog2(COLS))-1:0]         key_history,
    output logic [$clog2(HISTORY+1)-1:0]                           history_count,
    output logic [$clog2(ROWS)+$clog2(COLS)-1:0]                   current_key,
    output logic                                                   key_held,
    output logic                                                   key_press,
    output logic                                                   key_repeat,
    output logic                                                   key_release
);

    localparam int RW   = $clog2(ROWS);
    localparam int CW   = $clog2(COLS);
    localparam int KW   = RW + CW;
    localparam int DW   = $clog2(SCAN_CYCLES);
    localparam int CNTW = $clog2(DEBOUNCE_SCANS + 1);
    localparam int RPW  = (REPEAT_SCANS > 0) ? $clog2(REPEAT_SCANS + 1) : 1;
    localparam int HCW  = $clog2(HISTORY + 1);

    localparam logic [DW-1:0]   DWELL_LAST = DW'(SCAN_CYCLES - 1);
    localparam logic [RW-1:0]   ROW_LAST   = RW'(ROWS - 1);
    localparam logic [CNTW-1:0] DB_LAST    = CNTW'(DEBOUNCE_SCANS - 1);
    localparam logic [RPW-1:0]  RPT_LAST   = RPW'((REPEAT_SCANS > 0) ? REPEAT_SCANS - 1 : 0);
    localparam logic [HCW-1:0]  HCNT_MAX   = HCW'(HISTORY);

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

    state_t            state, state_nxt;
    logic [COLS-1:0]   col_meta, col_sync;
    logic [DW-1:0]     dwell_cnt;
    logic [RW-1:0]     row_idx;
    logic              sample, scan_end;

    logic              row_hit;
    logic [CW-1:0]     row_col;
    logic              acc_vld, acc_lock;
    logic [KW-1:0]     acc_code;
    logic              scan_cand_vld, scan_lock;
    logic [KW-1:0]     scan_cand;
    logic [RW-1:0]     lock_row;
    logic [CW-1:0]     lock_col;

    logic [CNTW-1:0]   cnt, cnt_nxt;
    logic [KW-1:0]     pend, pend_nxt;
    logic [RPW-1:0]    rpt, rpt_nxt;
    logic              accept, repeat_fire, release_fire;
    logic              hist_shift;
    logic [KW-1:0]     hist_code;
    logic [KW-1:0]     hist [HISTORY];

    // Two-flop synchroniser; resets to "nothing pressed" (pull-ups high)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_meta <= '1;
            col_sync <= '1;
        end else begin
            col_meta <= keypad_column;
            col_sync <= col_meta;
        end
    end

    // Row dwell counter and row pointer, advancing after the last dwell cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dwell_cnt <= '0;
            row_idx   <= '0;
        end else if (dwell_cnt == DWELL_LAST) begin
            dwell_cnt <= '0;
            row_idx   <= (row_idx == ROW_LAST) ? '0 : row_idx + RW'(1);
        end else begin
            dwell_cnt <= dwell_cnt + DW'(1);
        end
    end

    assign sample   = (dwell_cnt == DWELL_LAST);
    assign scan_end = sample && (row_idx == ROW_LAST);

    // Lowest pressed column of the currently driven row
    always_comb begin
        row_hit = 1'b0;
        row_col = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (!col_sync[c]) begin
                row_hit = 1'b1;
                row_col = CW'(c);
            end
        end
    end

    // Scan results so far including the row being sampled now; at scan-end these are the full-scan results
    assign lock_row      = current_key[KW-1:CW];
    assign lock_col      = current_key[CW-1:0];
    assign scan_cand_vld = acc_vld | row_hit;
    assign scan_cand     = acc_vld ? acc_code : {row_idx, row_col};
    assign scan_lock     = acc_lock | ((row_idx == lock_row) && !col_sync[lock_col]);

    // Per-scan accumulators, cleared at each scan-end so every scan is judged on its own
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_vld  <= 1'b0;
            acc_code <= '0;
            acc_lock <= 1'b0;
        end else if (sample) begin
            if (scan_end) begin
                acc_vld  <= 1'b0;
                acc_code <= '0;
                acc_lock <= 1'b0;
            end else begin
                acc_vld  <= scan_cand_vld;
                acc_code <= scan_cand;
                acc_lock <= scan_lock;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next state and counter updates, evaluated only at scan-end
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        pend_nxt     = pend;
        rpt_nxt      = rpt;
        accept       = 1'b0;
        repeat_fire  = 1'b0;
        release_fire = 1'b0;
        if (scan_end) begin
            case (state)
                IDLE: begin
                    if (scan_cand_vld) begin
                        pend_nxt = scan_cand;
                        if (DEBOUNCE_SCANS == 1) begin
                            accept    = 1'b1;
                            cnt_nxt   = '0;
                            rpt_nxt   = '0;
                            state_nxt = HELD;
                        end else begin
                            cnt_nxt   = CNTW'(1);
                            state_nxt = PRESS_DB;
                        end
                    end
                end
                PRESS_DB: begin
                    if (!scan_cand_vld) begin
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else if (scan_cand == pend) begin
                        if (cnt == DB_LAST) begin
                            accept    = 1'b1;
                            cnt_nxt   = '0;
                            rpt_nxt   = '0;
                            state_nxt = HELD;
                        end else begin
                            cnt_nxt = cnt + CNTW'(1);
                        end
                    end else begin
                        pend_nxt = scan_cand;
                        cnt_nxt  = CNTW'(1);
                    end
                end
                HELD: begin
                    if (!scan_lock) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            release_fire = 1'b1;
                            cnt_nxt      = '0;
                            state_nxt    = IDLE;
                        end else begin
                            cnt_nxt   = CNTW'(1);
                            state_nxt = REL_DB;
                        end
                    end else if (REPEAT_SCANS > 0) begin
                        if (rpt == RPT_LAST) begin
                            repeat_fire = 1'b1;
                            rpt_nxt     = '0;
                        end else begin
                            rpt_nxt = rpt + RPW'(1);
                        end
                    end
                end
                REL_DB: begin
                    if (scan_lock) begin
                        cnt_nxt   = '0;
                        state_nxt = HELD;
                    end else if (cnt == DB_LAST) begin
                        release_fire = 1'b1;
                        cnt_nxt      = '0;
                        state_nxt    = IDLE;
                    end else begin
                        cnt_nxt = cnt + CNTW'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // FSM outputs: row drive and the history write selection
    always_comb begin
        keypad_row          = '1;
        keypad_row[row_idx] = 1'b0;
        hist_shift          = accept | repeat_fire;
        hist_code           = accept ? pend_nxt : current_key;
    end

    // Registered datapath: counters, locked key, history and event pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt           <= '0;
            pend          <= '0;
            rpt           <= '0;
            current_key   <= '0;
            key_held      <= 1'b0;
            key_press     <= 1'b0;
            key_repeat    <= 1'b0;
            key_release   <= 1'b0;
            history_count <= '0;
            for (int i = 0; i < HISTORY; i++) hist[i] <= '0;
        end else begin
            cnt         <= cnt_nxt;
            pend        <= pend_nxt;
            rpt         <= rpt_nxt;
            key_press   <= accept;
            key_repeat  <= repeat_fire;
            key_release <= release_fire;
            if (accept) begin
                current_key <= pend_nxt;
                key_held    <= 1'b1;
            end else if (release_fire) begin
                current_key <= '0;
                key_held    <= 1'b0;
            end
            if (hist_shift) begin
                for (int i = HISTORY - 1; i > 0; i--) hist[i] <= hist[i-1];
                hist[0] <= hist_code;
                if (history_count != HCNT_MAX) history_count <= history_count + HCW'(1);
            end
        end
    end

    for (genvar g = 0; g < HISTORY; g++) begin : g_hist
        assign key_history[g*KW +: KW] = hist[g];
    end

endmodule
